// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-fetch slice: fetch FSM encoding,
// instruction size and the default reset vector.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_next_pc_32.sv
// Combinational next-PC selection: jr > jump > taken branch > sequential.
// All additions wrap modulo 2^32.
module next_pc_32
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_offset_i,
  input  logic        jump_i,
  input  logic [25:0] jump_target_i,
  input  logic        jr_i,
  input  logic [31:0] jr_addr_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o
);

  logic signed [31:0] br_disp;

  always_comb begin
    pc_plus4_o = pc_i + 32'(INSTR_BYTES);
    // Word offset: sign-extend the 16-bit immediate and scale by 4.
    br_disp    = {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};
    next_pc_o  = pc_plus4_o;
    if (jr_i)
      next_pc_o = jr_addr_i;
    else if (jump_i)
      next_pc_o = {pc_plus4_o[31:28], jump_target_i, 2'b00};
    else if (branch_taken_i)
      next_pc_o = pc_plus4_o + $unsigned(br_disp);
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: IDLE/FETCH/ISSUE/HALT FSM with imem wait timeout.
// Optional macro IFETCH_ALIGN_CHECK_EN halts on a misaligned jr target.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        err_timeout,
  output logic        err_misaligned
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  fetch_state_e      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              err_to_q, err_to_d;
  logic              err_mis_q, err_mis_d;
  logic [31:0]       jr_addr_eff;
  logic [31:0]       next_pc;
  logic              jr_misaligned;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign jr_addr_eff   = jr_addr;
  assign jr_misaligned = jr && (jr_addr[1:0] != 2'b00);
`else
  logic unused_jr_lsb;
  assign unused_jr_lsb = ^jr_addr[1:0];
  assign jr_addr_eff   = {jr_addr[31:2], 2'b00};
  assign jr_misaligned = 1'b0;
`endif

  next_pc_32 u_next_pc (
    .pc_i            (pc_q),
    .branch_taken_i  (branch_taken),
    .branch_offset_i (branch_offset),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .jr_i            (jr),
    .jr_addr_i       (jr_addr_eff),
    .pc_plus4_o      (pc_plus4),
    .next_pc_o       (next_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    wait_d      = wait_q;
    err_to_d    = err_to_q;
    err_mis_d   = err_mis_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    wait_inc    = wait_q + WAIT_W'(1);
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_data;
          wait_d  = '0;
          state_d = ST_ISSUE;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_W'(MAX_WAIT)) begin
            err_to_d = 1'b1;
            state_d  = ST_HALT;
          end
        end
      end
      ST_ISSUE: begin
        instr_valid = 1'b1;
        if (instr_accept) begin
          // A misaligned jr freezes pc so the faulting instruction stays visible.
          if (jr_misaligned) begin
            err_mis_d = 1'b1;
            state_d   = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      wait_q    <= '0;
      err_to_q  <= 1'b0;
      err_mis_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      wait_q    <= wait_d;
      err_to_q  <= err_to_d;
      err_mis_q <= err_mis_d;
    end
  end

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign instruction    = instr_q;
  assign err_timeout    = err_to_q;
  assign err_misaligned = err_mis_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch; honours IFETCH_ALIGN_CHECK_EN.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_accept;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        err_timeout;
  logic        err_misaligned;

  int errors = 0;
  int checks = 0;

  instruction_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .instr_accept   (instr_accept),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .jump           (jump),
    .jump_target    (jump_target),
    .jr             (jr),
    .jr_addr        (jr_addr),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .err_timeout    (err_timeout),
    .err_misaligned (err_misaligned)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    imem_ack      = 1'b0;
    imem_data     = 32'h0;
    instr_accept  = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 16'h0;
    jump          = 1'b0;
    jump_target   = 26'h0;
    jr            = 1'b0;
    jr_addr       = 32'h0;
  endtask

  // Zero-wait memory response in the current FETCH cycle.
  task automatic ack_now(input logic [31:0] data);
    imem_ack  = 1'b1;
    imem_data = data;
    step();
    imem_ack  = 1'b0;
  endtask

  task automatic accept_with(input logic jr_i, input logic [31:0] jr_addr_i,
                             input logic jump_i, input logic [25:0] tgt_i,
                             input logic br_i, input logic [15:0] off_i);
    instr_accept  = 1'b1;
    jr            = jr_i;
    jr_addr       = jr_addr_i;
    jump          = jump_i;
    jump_target   = tgt_i;
    branch_taken  = br_i;
    branch_offset = off_i;
    step();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instruction: got %h want 0", instruction); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h want 4", pc_plus4); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout: got %b want 0", err_timeout); end
    checks++; if (err_misaligned !== 1'b0) begin errors++; $display("FAIL reset_err_misaligned: got %b want 0", err_misaligned); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    reset = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      exp_addr  = 32'(i * 4);
      exp_instr = 32'hA000_0000 | 32'(i);
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d]: got %b want 1", i, imem_req); end
      checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, exp_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_valid_lo[%0d]: got %b want 0", i, instr_valid); end
      ack_now(exp_instr);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid_hi[%0d]: got %b want 1", i, instr_valid); end
      checks++; if (instruction !== exp_instr) begin errors++; $display("FAIL seq_instr[%0d]: got %h want %h", i, instruction, exp_instr); end
      checks++; if (pc !== exp_addr) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, exp_addr); end
      checks++; if (pc_plus4 !== exp_addr + 32'h4) begin errors++; $display("FAIL seq_pc4[%0d]: got %h want %h", i, pc_plus4, exp_addr + 32'h4); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_req_issue[%0d]: got %b want 0", i, imem_req); end
      if (i == 1) begin
        // Stray ack and redirects without accept must change nothing.
        imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        branch_taken = 1'b1; branch_offset = 16'h0010; jr = 1'b1; jr_addr = 32'h300;
        step();
        clear_inputs();
        checks++; if (instruction !== exp_instr) begin errors++; $display("FAIL stray_ack_instr: got %h want %h", instruction, exp_instr); end
        checks++; if (pc !== exp_addr) begin errors++; $display("FAIL stray_redirect_pc: got %h want %h", pc, exp_addr); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", instr_valid); end
      end
      accept_with(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0);
    end
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL seq_addr_end: got %h want 0000000c", imem_addr); end
  endtask

  task automatic test_branch();
    ack_now(32'h1);
    accept_with(1'b1, 32'h100, 1'b0, 26'h0, 1'b0, 16'h0);
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL jr_addr: got %h want 00000100", imem_addr); end
    ack_now(32'h2);
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL branch_pc: got %h want 00000100", pc); end
    accept_with(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'hFFFE);
    checks++; if (imem_addr !== 32'h0FC) begin errors++; $display("FAIL branch_back: got %h want 000000fc", imem_addr); end
  endtask

  task automatic test_jump();
    ack_now(32'h3);
    accept_with(1'b1, 32'h1000_0040, 1'b0, 26'h0, 1'b0, 16'h0);
    ack_now(32'h4);
    accept_with(1'b0, 32'h0, 1'b1, 26'h10, 1'b1, 16'h0004);
    checks++; if (imem_addr !== 32'h1000_0040) begin errors++; $display("FAIL jump_over_branch: got %h want 10000040", imem_addr); end
    ack_now(32'h5);
    accept_with(1'b1, 32'h200, 1'b1, 26'h3FF_FFFF, 1'b1, 16'h0004);
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL jr_over_jump: got %h want 00000200", imem_addr); end
    ack_now(32'h6);
    accept_with(1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 1'b0, 16'h0);
    ack_now(32'h7);
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want 00000000", pc_plus4); end
    accept_with(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", imem_addr); end
  endtask

  task automatic test_align();
    ack_now(32'h8);
    accept_with(1'b1, 32'h0000_0102, 1'b0, 26'h0, 1'b0, 16'h0);
`ifdef IFETCH_ALIGN_CHECK_EN
    checks++; if (err_misaligned !== 1'b1) begin errors++; $display("FAIL align_err: got %b want 1", err_misaligned); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL align_req: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL align_valid: got %b want 0", instr_valid); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL align_pc: got %h want 00000000", pc); end
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL align_halt_hold: got %b want 0", imem_req); end
`else
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL align_mask_addr: got %h want 00000100", imem_addr); end
    checks++; if (err_misaligned !== 1'b0) begin errors++; $display("FAIL align_err_tied: got %b want 0", err_misaligned); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL align_req: got %b want 1", imem_req); end
`endif
  endtask

  task automatic test_wait_timeout();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wait_hold[%0d]: got req=%b addr=%h want req=1 addr=0", k, imem_req, imem_addr); end
      if (k < 3) step();
    end
    ack_now(32'hC0DE_0001);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wait_valid: got %b want 1", instr_valid); end
    checks++; if (instruction !== 32'hC0DE_0001) begin errors++; $display("FAIL wait_instr: got %h want c0de0001", instruction); end
    accept_with(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0);
    for (int k = 0; k < 15; k++) begin
      checks++; if (imem_req !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early[%0d]: got req=%b err=%b want req=1 err=0", k, imem_req, err_timeout); end
      step();
    end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err_timeout); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL timeout_req: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid: got %b want 0", instr_valid); end
    imem_ack = 1'b1; imem_data = 32'h5555_5555;
    step(); step(); step();
    clear_inputs();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || err_timeout !== 1'b1) begin errors++; $display("FAIL halt_sticky: got req=%b valid=%b err=%b want 0 0 1", imem_req, instr_valid, err_timeout); end
  endtask

  task automatic test_reset_mid_fetch();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL midrst_pre_req: got %b want 1", imem_req); end
    reset = 1'b1; imem_ack = 1'b1; imem_data = 32'h1234_5678;
    step();
    reset = 1'b0; imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", instr_valid); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL midrst_instr: got %h want 0", instruction); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midrst_idle_req: got %b want 0", imem_req); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL midrst_err_clear: got %b want 0", err_timeout); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_refetch: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    step();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_issue: got %b want 0", instr_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_align();
    test_wait_timeout();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: address of the first fetch after reset.
REQ-002 Parameter MAX_WAIT, default 15: imem wait cycles tolerated before err_timeout.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  byte address of the requested word.
REQ-007 imem_ack  input  1  memory returns imem_data this cycle.
REQ-008 imem_data  input  32  fetched instruction word.
REQ-009 instruction  output  32  instruction presented to the datapath.
REQ-010 instr_valid  output  1  instruction is valid.
REQ-011 instr_accept  input  1  datapath retires the presented instruction this cycle.
REQ-012 branch_taken  input  1  conditional branch resolved taken; sampled with instr_accept.
REQ-013 branch_offset  input  16  raw immediate of the branch.
REQ-014 jump  input  1  j/jal redirect; sampled with instr_accept.
REQ-015 jump_target  input  26  26-bit jump field.
REQ-016 jr  input  1  register-indirect redirect; sampled with instr_accept.
REQ-017 jr_addr  input  32  register target.
REQ-018 pc  output  32  address of the presented instruction.
REQ-019 pc_plus4  output  32  pc + 4, link value for jal.
REQ-020 err_timeout  output  1  sticky; imem exceeded MAX_WAIT.
REQ-021 err_misaligned  output  1  sticky; misaligned jr target.

Function
REQ-022 States: IDLE, FETCH, ISSUE, HALT.
REQ-023 IDLE -> FETCH unconditionally on the first cycle after reset deasserts.
REQ-024 FETCH: imem_req=1, imem_addr=pc held stable; on imem_ack, latch imem_data into instruction; -> ISSUE next cycle.
REQ-025 Zero-wait memory (ack in the first FETCH cycle) is legal; minimum throughput is one instruction per 2 cycles.
REQ-026 ISSUE: instr_valid=1, imem_req=0; instruction and pc stable until instr_accept.
REQ-027 On instr_accept in ISSUE: pc <= next PC; -> FETCH next cycle.
REQ-028 Next-PC priority: jr > jump > branch_taken > sequential.
REQ-029 Sequential: pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-030 Branch: pc+4 + (sign-extended branch_offset << 2), modulo 2^32.
REQ-031 Jump: {pc_plus4[31:28], jump_target, 2'b00}.
REQ-032 Redirect inputs are ignored when instr_accept is low or the state is not ISSUE.
REQ-033 imem_ack outside FETCH is ignored.
REQ-034 Wait counter increments each FETCH cycle without ack; reaching MAX_WAIT sets err_timeout and -> HALT.
REQ-035 HALT: imem_req=0, instr_valid=0; exits only on reset.

Reset
REQ-036 Reset in any state, including mid-FETCH, abandons the request; next cycle is IDLE.
REQ-037 Reset values: pc=RESET_PC, instruction=0, instr_valid=0, imem_req=0, err_timeout=0, err_misaligned=0, wait counter=0.
REQ-038 pc_plus4 and imem_addr are always combinational from pc.

Configuration
REQ-039 IFETCH_ALIGN_CHECK_EN defined: jr with jr_addr[1:0]!=0 on accept sets err_misaligned, does not update pc, and -> HALT.
REQ-040 IFETCH_ALIGN_CHECK_EN undefined: jr_addr[1:0] forced to 2'b00; err_misaligned tied 0; port retained.

Structure
REQ-041 Shared package mips_pkg holds: fetch state encoding, INSTR_BYTES=4, default RESET_PC.
REQ-042 One combinational sub-module, next_pc_32, computes next PC from pc and the redirect inputs; the FSM and registers stay in instruction_fetch.

Verification
REQ-043 Sequential fetch: reset, zero-wait memory, accept every ISSUE -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid every second cycle.
REQ-044 Branch: pc=0x100, branch_taken, branch_offset=16'hFFFE -> next imem_addr 0x0FC.
REQ-045 Jump priority: pc=0x1000_0040, jump, jump_target=26'h10, branch_taken=1 simultaneously -> next imem_addr 0x1000_0040.
REQ-046 Wait/timeout: ack after 3 cycles -> imem_addr held 4 cycles, instruction latched; no ack for 15 cycles -> err_timeout=1, HALT, imem_req=0.
REQ-047 Reset mid-FETCH: reset asserted during wait, ack arrives in reset cycle -> instr_valid stays 0, first fetch after reset at RESET_PC.
REQ-048 Align check (macro on): jr, jr_addr=0x0000_0102 -> err_misaligned=1, HALT, pc unchanged; macro off -> next imem_addr 0x0000_0100.
